// File: rtl/clk_gen_pkg.sv
// Shared constants for the multi-channel clock/tick generator.
// Half-periods are counted in cycles of the 50 MHz board clock.
package clk_gen_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned CNT_W_DEF = 28;

  // Half-period in input cycles giving a 50% square wave at freq_hz.
  function automatic int unsigned hp_for(input int unsigned freq_hz);
    return CLK_HZ / (2 * freq_hz);
  endfunction

  localparam int unsigned HP_20HZ  = hp_for(20);
  localparam int unsigned HP_1KHZ  = hp_for(1_000);
  localparam int unsigned HP_20KHZ = hp_for(20_000);
  localparam int unsigned HP_1MHZ  = hp_for(1_000_000);

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active half-period, counter, divided clock and
// a one-cycle tick on each rising edge of the divided clock.
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned      CNT_W  = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HP = CNT_W'(HP_1KHZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_data,
  input  logic             i_en,
  input  logic             i_sync,
  output logic             o_clk,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] w_active_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;
  logic             w_term;

  // A write landing this cycle is visible to any reload happening this cycle.
  assign w_eff  = i_wr ? i_wr_data : r_shadow;
  assign w_term = (r_active != '0) && (r_cnt == r_active - CNT_W'(1));

  // Restart (sync or disable) > stalled (zero half-period) > terminal > count.
  always_comb begin
    w_active_nxt = r_active;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_clk_nxt    = r_clk;
    w_tick_nxt   = 1'b0;
    if (i_sync || !i_en) begin
      w_active_nxt = w_eff;
      w_cnt_nxt    = '0;
      w_clk_nxt    = 1'b0;
    end else if (r_active == '0) begin
      w_cnt_nxt    = '0;
      w_clk_nxt    = 1'b0;
    end else if (w_term) begin
      w_active_nxt = w_eff;
      w_cnt_nxt    = '0;
      w_clk_nxt    = ~r_clk;
      w_tick_nxt   = ~r_clk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= DEF_HP;
      r_active <= DEF_HP;
      r_cnt    <= '0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_shadow <= w_eff;
      r_active <= w_active_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk    <= w_clk_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_gen_multi.sv
// N-channel clock/tick generator: write-address decode plus one clk_div_ch
// per channel. Outputs are registered enables, not clocks.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int unsigned               NUM_CH = 4,
  parameter int unsigned               CNT_W  = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]   DEF_HP = {CNT_W'(HP_1MHZ), CNT_W'(HP_1KHZ),
                                                 CNT_W'(HP_20KHZ), CNT_W'(HP_20HZ)},
  localparam int unsigned              AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk_50MHz,
  input  logic              nRst,
  input  logic              Wr_En,
  input  logic [AW-1:0]     Wr_Addr,
  input  logic [CNT_W-1:0]  Wr_Data,
  input  logic [NUM_CH-1:0] Ch_En,
  input  logic              Sync,
  output logic [NUM_CH-1:0] Clk_Out,
  output logic [NUM_CH-1:0] Tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_wr_sel;

    // Exact match per channel, so addresses >= NUM_CH select nothing.
    assign w_wr_sel = Wr_En && (Wr_Addr == AW'(i));

    clk_div_ch #(
      .CNT_W  (CNT_W),
      .DEF_HP (DEF_HP[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk       (Clk_50MHz),
      .rst_n     (nRst),
      .i_wr      (w_wr_sel),
      .i_wr_data (Wr_Data),
      .i_en      (Ch_En[i]),
      .i_sync    (Sync),
      .o_clk     (Clk_Out[i]),
      .o_tick    (Tick[i])
    );
  end

endmodule
